video_timing_gen: RTL and testbench

//  Raster timing generator and pixel mux that drives a video_bus.out modport: hsync, vsync, blank, border, data[31:0].

---
 rtl/video_timing_gen.sv | 187 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator and pixel mux for a video bus.
//   Generates hctr/vctr raster counters, requests interior pixels from a
//   fixed-latency pixel source, and aligns the returned data with delayed
//   hsync/vsync/blank/border/sof. Border band carries border_color_i and
//   blanking carries zero. Every output lags the counter state by PIX_LAT+1.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   en_i              timing enable (low: counters and pipeline idle)
//   border_color_i    colour substituted in the border band
//   pix_req_o         interior pixel request; pix_x_o/pix_y_o interior coords
//   pix_dat_i         pixel data, valid PIX_LAT clocks after pix_req_o
//   sof_o             start-of-frame pulse, aligned with vbus outputs
//   vbus_*_o          video bus: clk, hsync, vsync, blank, border, data
// Optional build macro VIDEO_TPG_EN adds tpg_sel_i, an internal test pattern
// that replaces pix_dat_i in the interior when high.
module video_timing_gen #(
  parameter int   HVIS      = 800,
  parameter int   HFP       = 40,
  parameter int   HSW       = 128,
  parameter int   HBP       = 88,
  parameter int   VVIS      = 600,
  parameter int   VFP       = 1,
  parameter int   VSW       = 4,
  parameter int   VBP       = 23,
  parameter int   HBORDER   = 16,
  parameter int   VBORDER   = 16,
  parameter logic HSYNC_POL = 1'b1,
  parameter logic VSYNC_POL = 1'b1,
  parameter int   PIX_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [31:0] border_color_i,
`ifdef VIDEO_TPG_EN
  input  logic        tpg_sel_i,
`endif
  output logic        pix_req_o,
  output logic [15:0] pix_x_o,
  output logic [15:0] pix_y_o,
  input  logic [31:0] pix_dat_i,
  output logic        sof_o,
  output logic        vbus_clk_o,
  output logic        vbus_hsync_o,
  output logic        vbus_vsync_o,
  output logic        vbus_blank_o,
  output logic        vbus_border_o,
  output logic [31:0] vbus_data_o
);

  localparam int HTOT = HVIS + HFP + HSW + HBP;
  localparam int VTOT = VVIS + VFP + VSW + VBP;

  localparam logic [15:0] H_LAST = 16'(HTOT - 1);
  localparam logic [15:0] V_LAST = 16'(VTOT - 1);
  localparam logic [15:0] H_VIS  = 16'(HVIS);
  localparam logic [15:0] V_VIS  = 16'(VVIS);
  localparam logic [15:0] HS_LO  = 16'(HVIS + HFP);
  localparam logic [15:0] HS_HI  = 16'(HVIS + HFP + HSW);
  localparam logic [15:0] VS_LO  = 16'(VVIS + VFP);
  localparam logic [15:0] VS_HI  = 16'(VVIS + VFP + VSW);
  localparam logic [15:0] HB_LO  = 16'(HBORDER);
  localparam logic [15:0] HB_HI  = 16'(HVIS - HBORDER);
  localparam logic [15:0] VB_LO  = 16'(VBORDER);
  localparam logic [15:0] VB_HI  = 16'(VVIS - VBORDER);

  // hs/vs hold the active state; polarity is applied only at the pins.
  // word carries border colour or test pattern; use_src marks that the
  // final stage must take pix_dat_i instead.
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        border;
    logic        sof;
    logic        use_src;
    logic [31:0] word;
  } stage_t;

  localparam stage_t STAGE_IDLE = '{hs: 1'b0, vs: 1'b0, blank: 1'b1, border: 1'b0,
                                    sof: 1'b0, use_src: 1'b0, word: 32'h0};

  function automatic logic in_interior(input logic [15:0] h, input logic [15:0] v);
    return (h >= HB_LO) && (h < HB_HI) && (v >= VB_LO) && (v < VB_HI);
  endfunction

  logic [15:0] hctr_q, hctr_d, vctr_q, vctr_d;
  logic        pix_req_q, pix_req_d;
  logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  stage_t      pipe_q [PIX_LAT+1];
  stage_t      pipe_d [PIX_LAT+1];
  stage_t      s0;
  logic        interior;
  logic        tpg_on;
  logic [31:0] tpg_word;

`ifdef VIDEO_TPG_EN
  logic [7:0] px8, py8;
  assign px8      = 8'(hctr_q - HB_LO);
  assign py8      = 8'(vctr_q - VB_LO);
  assign tpg_on   = tpg_sel_i;
  assign tpg_word = {8'hFF, px8, py8, px8 ^ py8};
`else
  assign tpg_on   = 1'b0;
  assign tpg_word = 32'h0;
`endif

  always_comb begin
    hctr_d = hctr_q;
    vctr_d = vctr_q;
    if (!en_i) begin
      hctr_d = '0;
      vctr_d = '0;
    end else if (hctr_q == H_LAST) begin
      hctr_d = '0;
      vctr_d = (vctr_q == V_LAST) ? 16'd0 : vctr_q + 16'd1;
    end else begin
      hctr_d = hctr_q + 16'd1;
    end
  end

  // The request is registered from the next counter state so that it lines
  // up with the counter itself; the source then returns data exactly when
  // the final pipeline stage samples it.
  always_comb begin
    pix_req_d = in_interior(hctr_d, vctr_d);
    pix_x_d   = pix_req_d ? hctr_d - HB_LO : 16'd0;
    pix_y_d   = pix_req_d ? vctr_d - VB_LO : 16'd0;
  end

  assign interior = in_interior(hctr_q, vctr_q);

  always_comb begin
    s0         = STAGE_IDLE;
    s0.hs      = (hctr_q >= HS_LO) && (hctr_q < HS_HI);
    s0.vs      = (vctr_q >= VS_LO) && (vctr_q < VS_HI);
    s0.blank   = !((hctr_q < H_VIS) && (vctr_q < V_VIS));
    s0.border  = !s0.blank && !interior;
    s0.sof     = (hctr_q == 16'd0) && (vctr_q == 16'd0);
    s0.use_src = interior && !tpg_on;
    if (s0.border) begin
      s0.word = border_color_i;
    end else if (interior && tpg_on) begin
      s0.word = tpg_word;
    end
  end

  always_comb begin
    for (int i = 0; i <= PIX_LAT; i++) pipe_d[i] = STAGE_IDLE;
    if (en_i) begin
      pipe_d[0] = s0;
      for (int i = 1; i < PIX_LAT; i++) pipe_d[i] = pipe_q[i-1];
      pipe_d[PIX_LAT] = pipe_q[PIX_LAT-1];
      if (pipe_q[PIX_LAT-1].use_src) pipe_d[PIX_LAT].word = pix_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hctr_q    <= '0;
      vctr_q    <= '0;
      pix_req_q <= 1'b0;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      for (int i = 0; i <= PIX_LAT; i++) pipe_q[i] <= STAGE_IDLE;
    end else begin
      hctr_q    <= hctr_d;
      vctr_q    <= vctr_d;
      pix_req_q <= pix_req_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      for (int i = 0; i <= PIX_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign pix_req_o     = pix_req_q;
  assign pix_x_o       = pix_x_q;
  assign pix_y_o       = pix_y_q;
  assign sof_o         = pipe_q[PIX_LAT].sof;
  assign vbus_clk_o    = clk;
  assign vbus_hsync_o  = pipe_q[PIX_LAT].hs ? HSYNC_POL : ~HSYNC_POL;
  assign vbus_vsync_o  = pipe_q[PIX_LAT].vs ? VSYNC_POL : ~VSYNC_POL;
  assign vbus_blank_o  = pipe_q[PIX_LAT].blank;
  assign vbus_border_o = pipe_q[PIX_LAT].border;
  assign vbus_data_o   = pipe_q[PIX_LAT].word;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

  localparam int HTOT  = 24;
  localparam int FRAME = 288;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] border_color = 32'h0;
  logic [31:0] pix_dat;
  logic        pix_req, sof, vclk, hsync, vsync, blank, border;
  logic [15:0] pix_x, pix_y;
  logic [31:0] data;
`ifdef VIDEO_TPG_EN
  logic        tpg_sel = 1'b0;
`endif

  video_timing_gen #(
    .HVIS(16), .HFP(2), .HSW(3), .HBP(3),
    .VVIS(8), .VFP(1), .VSW(2), .VBP(1),
    .HBORDER(2), .VBORDER(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIX_LAT(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .border_color_i(border_color),
`ifdef VIDEO_TPG_EN
    .tpg_sel_i(tpg_sel),
`endif
    .pix_req_o(pix_req), .pix_x_o(pix_x), .pix_y_o(pix_y), .pix_dat_i(pix_dat),
    .sof_o(sof), .vbus_clk_o(vclk), .vbus_hsync_o(hsync), .vbus_vsync_o(vsync),
    .vbus_blank_o(blank), .vbus_border_o(border), .vbus_data_o(data)
  );

  always #5 clk = ~clk;

  // Pixel source: returns {pix_y,pix_x} two clocks after a request, garbage otherwise.
  logic [31:0] src1, src2;
  always @(posedge clk) begin
    src1 <= pix_req ? {pix_y, pix_x} : $urandom;
    src2 <= src1;
  end
  assign pix_dat = src2;

  typedef struct packed {
    logic        req;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        border;
    logic [31:0] data;
  } obs_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          ec = 0;              // clocks since timing (re)started
  bit          tpg_mode = 1'b0;
  logic [31:0] col_hist [1024];     // border colour present during each counter position

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.blank = 1'b1;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.req = pix_req; o.x = pix_x; o.y = pix_y; o.sof = sof;
    o.hs = hsync; o.vs = vsync; o.blank = blank; o.border = border; o.data = data;
    return o;
  endfunction

  // Raster position p = clocks since start; outputs show position ec-LAT.
  function automatic obs_t model(input int n);
    obs_t e;
    int p, h, v;
    bit inner;
    e = idle_obs();
    p = n % FRAME; h = p % HTOT; v = p / HTOT;
    inner = (h >= 2 && h < 14 && v >= 2 && v < 6);
    e.req = inner;
    if (inner) begin
      e.x = 16'(h - 2);
      e.y = 16'(v - 2);
    end
    if (n >= LAT) begin
      p = (n - LAT) % FRAME; h = p % HTOT; v = p / HTOT;
      e.sof    = (p == 0);
      e.hs     = (h >= 18 && h < 21);
      e.vs     = (v >= 9 && v < 11);
      e.blank  = !(h < 16 && v < 8);
      e.border = !e.blank && (h < 2 || h >= 14 || v < 2 || v >= 6);
      if (e.border) e.data = col_hist[(n - LAT) % 1024];
      else if (!e.blank)
        e.data = tpg_mode ? {8'hFF, 8'(h - 2), 8'(v - 2), 8'(h - 2) ^ 8'(v - 2)}
                          : {16'(v - 2), 16'(h - 2)};
    end
    return e;
  endfunction

  task automatic tick(input bit rand_col);
    bit act;
    @(posedge clk);
    act = en && rst_n;
    #1;
    ec = act ? ec + 1 : 0;
    if (rand_col) border_color = $urandom;
    col_hist[ec % 1024] = border_color;
  endtask

  task automatic restart();
    en = 1'b0;
    tick(1'b0);
    en = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o;
    rst_n = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = observe();
    tests_run++;
    if (o !== idle_obs()) begin
      tests_failed++;
      $display("FAIL reset_state actual=%h required=%h", o, idle_obs());
    end
    tests_run++;
    if (vclk !== clk) begin
      tests_failed++;
      $display("FAIL vbus_clk_high actual=%b required=%b", vclk, clk);
    end
    @(negedge clk); #1;
    tests_run++;
    if (vclk !== clk) begin
      tests_failed++;
      $display("FAIL vbus_clk_low actual=%b required=%b", vclk, clk);
    end
  endtask

  task automatic test_timing();
    obs_t o, e;
    int vs_cnt = 0, sof_cnt = 0, first_sof = -1, first_vs = -1;
    @(posedge clk); #1;
    border_color = $urandom;
    en = 1'b1; rst_n = 1'b1;
    ec = 0; col_hist[0] = border_color;
    for (int c = 0; c < 2 * FRAME + 2; c++) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL timing ec=%0d actual=%h required=%h", ec, o, e);
      end
      if (o.vs === 1'b1) begin
        vs_cnt++;
        if (first_vs < 0) first_vs = ec;
      end
      if (o.sof === 1'b1) begin
        sof_cnt++;
        if (first_sof < 0) first_sof = ec;
      end
    end
    tests_run++;
    if (first_sof != 3) begin
      tests_failed++; $display("FAIL first_sof actual=%0d required=3", first_sof);
    end
    tests_run++;
    if (sof_cnt != 2) begin
      tests_failed++; $display("FAIL sof_count actual=%0d required=2", sof_cnt);
    end
    tests_run++;
    if (first_vs != 219) begin
      tests_failed++; $display("FAIL vsync_start actual=%0d required=219", first_vs);
    end
    tests_run++;
    if (vs_cnt != 96) begin
      tests_failed++; $display("FAIL vsync_clocks actual=%0d required=96", vs_cnt);
    end
  endtask

  task automatic test_border_and_source();
    obs_t o, e;
    border_color = 32'h00FF0000;
    restart();
    for (int c = 0; c < FRAME + 3; c++) begin
      tick(1'b0);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL border_frame ec=%0d actual=%h required=%h", ec, o, e);
      end
      if (ec == LAT + 7) begin
        tests_run++;
        if (data !== 32'h00FF0000 || border !== 1'b1) begin
          tests_failed++;
          $display("FAIL line0_border actual=%h/%b required=00ff0000/1", data, border);
        end
      end
      if (ec == LAT + 2 * HTOT + 1 || ec == LAT + 2 * HTOT + 14) begin
        tests_run++;
        if (border !== 1'b1) begin
          tests_failed++; $display("FAIL line2_edge ec=%0d actual=%b required=1", ec, border);
        end
      end
      if (ec == LAT + 2 * HTOT + 2) begin
        tests_run++;
        if (border !== 1'b0) begin
          tests_failed++; $display("FAIL line2_inner actual=%b required=0", border);
        end
      end
      if (ec == LAT + 3 * HTOT + 5) begin
        tests_run++;
        if (data !== 32'h0001_0003) begin
          tests_failed++; $display("FAIL line3_px5 actual=%h required=00010003", data);
        end
      end
      if (ec == LAT + 3 * HTOT + 19) begin
        tests_run++;
        if (data !== 32'h0 || blank !== 1'b1) begin
          tests_failed++; $display("FAIL blank_data actual=%h/%b required=0/1", data, blank);
        end
      end
    end
  endtask

  task automatic test_en_drop();
    obs_t o, e;
    int hold;
    restart();
    while (ec < 4 * HTOT + 10) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL pre_drop ec=%0d actual=%h required=%h", ec, o, e);
      end
    end
    en = 1'b0;
    hold = $urandom_range(1, 5);
    for (int c = 0; c < hold; c++) begin
      tick(1'b1);
      o = observe();
      tests_run++;
      if (o !== idle_obs()) begin
        tests_failed++;
        $display("FAIL en_low_idle c=%0d actual=%h required=%h", c, o, idle_obs());
      end
    end
    en = 1'b1;
    for (int c = 0; c < 2 * HTOT; c++) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL en_restart ec=%0d actual=%h required=%h", ec, o, e);
      end
      if (ec == LAT) begin
        tests_run++;
        if (sof !== 1'b1) begin
          tests_failed++; $display("FAIL restart_sof actual=%b required=1", sof);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    int run;
    run = $urandom_range(50, 250);
    for (int c = 0; c < run; c++) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL pre_reset ec=%0d actual=%h required=%h", ec, o, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    o = observe();
    tests_run++;
    if (o !== idle_obs()) begin
      tests_failed++;
      $display("FAIL async_reset actual=%h required=%h", o, idle_obs());
    end
    tick(1'b1);
    o = observe();
    tests_run++;
    if (o !== idle_obs()) begin
      tests_failed++;
      $display("FAIL reset_hold actual=%h required=%h", o, idle_obs());
    end
    #3 rst_n = 1'b1;
    for (int c = 0; c < FRAME + 3; c++) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL post_reset ec=%0d actual=%h required=%h", ec, o, e);
      end
    end
  endtask

`ifdef VIDEO_TPG_EN
  task automatic test_tpg();
    obs_t o, e;
    tpg_sel = 1'b1; tpg_mode = 1'b1;
    restart();
    for (int c = 0; c < FRAME + 3; c++) begin
      tick(1'b1);
      o = observe(); e = model(ec);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL tpg_frame ec=%0d actual=%h required=%h", ec, o, e);
      end
      if (ec == LAT + 3 * HTOT + 5) begin
        tests_run++;
        if (data !== 32'hFF03_0102) begin
          tests_failed++; $display("FAIL tpg_px actual=%h required=ff030102", data);
        end
      end
    end
    tpg_sel = 1'b0; tpg_mode = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_timing();
    test_border_and_source();
    test_en_drop();
    test_async_reset();
`ifdef VIDEO_TPG_EN
    test_tpg();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
